triangle_rasterizer: RTL

- Sequential counterpart to the combinational point-in-triangle test: given three vertices, it generates every integer pixel inside the triangle.
- Walks the triangle's bounding box in raster order and evaluates one candidate per cycle using the same edge-function sign test.
- Emits the covered pixels on a valid/ready stream to downstream fill/framebuffer logic.

---
 rtl/triangle_rasterizer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/triangle_rasterizer.sv
// Triangle rasterizer: walks the vertex bounding box in raster order, tests
// one candidate pixel per cycle with three edge functions and streams the
// covered pixels out on a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for start; vertices latched on an accepted start
// SETUP | bounding box computed, scan position set to (xmin, ymin)
// SCAN  | one candidate evaluated per cycle whenever the output slot is free
// DRAIN | last candidate done; waiting for the final pixel to be taken
module triangle_rasterizer #(
    parameter int CW   = 12,
    parameter int CNTW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CW-1:0]   P1X,
    input  logic [CW-1:0]   P1Y,
    input  logic [CW-1:0]   P2X,
    input  logic [CW-1:0]   P2Y,
    input  logic [CW-1:0]   P3X,
    input  logic [CW-1:0]   P3Y,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_x,
    output logic [CW-1:0]   out_y,
    output logic            done,
    output logic [CNTW-1:0] pix_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam int EW = 2*CW + 3;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   p1x_q, p1y_q, p2x_q, p2y_q, p3x_q, p3y_q;
    logic [CW-1:0]   p1x_d, p1y_d, p2x_d, p2y_d, p3x_d, p3y_d;
    logic [CW-1:0]   xmin_q, xmax_q, ymin_q, ymax_q;
    logic [CW-1:0]   xmin_d, xmax_d, ymin_d, ymax_d;
    logic [CW-1:0]   cx_q, cy_q, cx_d, cy_d;
    logic [CW-1:0]   ox_q, oy_q, ox_d, oy_d;
    logic            ov_q, ov_d;
    logic            done_q, done_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic signed [EW-1:0] e12, e23, e31;
    logic            pos_any, neg_any, covered, out_free;

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // E = (TX-BX)*(AY-BY) - (AX-BX)*(TY-BY), full precision. Differences are
    // sign-extended by hand so the multiply and subtract never lose bits.
    function automatic logic signed [EW-1:0] edge_fn(
        input logic [CW-1:0] tx, ty, ax, ay, bx, by
    );
        logic signed [CW:0]     dtx, day, dax, dty;
        logic signed [2*CW+1:0] m1, m2;
        dtx = {1'b0, tx} - {1'b0, bx};
        day = {1'b0, ay} - {1'b0, by};
        dax = {1'b0, ax} - {1'b0, bx};
        dty = {1'b0, ty} - {1'b0, by};
        m1  = {{(CW+1){dtx[CW]}}, dtx} * {{(CW+1){day[CW]}}, day};
        m2  = {{(CW+1){dax[CW]}}, dax} * {{(CW+1){dty[CW]}}, dty};
        return {m1[2*CW+1], m1} - {m2[2*CW+1], m2};
    endfunction

    assign e12 = edge_fn(cx_q, cy_q, p1x_q, p1y_q, p2x_q, p2y_q);
    assign e23 = edge_fn(cx_q, cy_q, p2x_q, p2y_q, p3x_q, p3y_q);
    assign e31 = edge_fn(cx_q, cy_q, p3x_q, p3y_q, p1x_q, p1y_q);

    // Inside unless some edge is strictly positive while another is strictly
    // negative; this accepts both windings and includes edges and vertices.
    assign pos_any  = (!e12[EW-1] && |e12) || (!e23[EW-1] && |e23) || (!e31[EW-1] && |e31);
    assign neg_any  = e12[EW-1] || e23[EW-1] || e31[EW-1];
    assign covered  = !(pos_any && neg_any);
    assign out_free = !ov_q || out_ready;

    assign busy      = (state_q != S_IDLE);
    assign out_valid = ov_q;
    assign out_x     = ox_q;
    assign out_y     = oy_q;
    assign done      = done_q;
    assign pix_count = cnt_q;

    // Next-state logic for the sequencer, scan position and output slot.
    always_comb begin
        state_d = state_q;
        p1x_d = p1x_q; p1y_d = p1y_q;
        p2x_d = p2x_q; p2y_d = p2y_q;
        p3x_d = p3x_q; p3y_d = p3y_q;
        xmin_d = xmin_q; xmax_d = xmax_q;
        ymin_d = ymin_q; ymax_d = ymax_q;
        cx_d = cx_q; cy_d = cy_q;
        ov_d = ov_q; ox_d = ox_q; oy_d = oy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p1x_d = P1X; p1y_d = P1Y;
                    p2x_d = P2X; p2y_d = P2Y;
                    p3x_d = P3X; p3y_d = P3Y;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                xmin_d  = min3(p1x_q, p2x_q, p3x_q);
                xmax_d  = max3(p1x_q, p2x_q, p3x_q);
                ymin_d  = min3(p1y_q, p2y_q, p3y_q);
                ymax_d  = max3(p1y_q, p2y_q, p3y_q);
                cx_d    = xmin_d;
                cy_d    = ymin_d;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (out_free) begin
                    if (covered) begin
                        ov_d  = 1'b1;
                        ox_d  = cx_q;
                        oy_d  = cy_q;
                        cnt_d = cnt_q + CNTW'(1);
                    end else begin
                        ov_d = 1'b0;
                    end
                    if (cx_q == xmax_q) begin
                        if (cy_q == ymax_q) begin
                            state_d = S_DRAIN;
                        end else begin
                            cx_d = xmin_q;
                            cy_d = cy_q + CW'(1);
                        end
                    end else begin
                        cx_d = cx_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_free) begin
                    ov_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any job immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            p1x_q <= '0; p1y_q <= '0;
            p2x_q <= '0; p2y_q <= '0;
            p3x_q <= '0; p3y_q <= '0;
            xmin_q <= '0; xmax_q <= '0;
            ymin_q <= '0; ymax_q <= '0;
            cx_q <= '0; cy_q <= '0;
            ov_q <= 1'b0; ox_q <= '0; oy_q <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            p1x_q <= p1x_d; p1y_q <= p1y_d;
            p2x_q <= p2x_d; p2y_q <= p2y_d;
            p3x_q <= p3x_d; p3y_q <= p3y_d;
            xmin_q <= xmin_d; xmax_q <= xmax_d;
            ymin_q <= ymin_d; ymax_q <= ymax_d;
            cx_q <= cx_d; cy_q <= cy_d;
            ov_q <= ov_d; ox_q <= ox_d; oy_q <= oy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
